sprite_game_engine: RTL and testbench
=====================================

Name: sprite_game_engine

Overview:
- Parametrised successor to the single-player VGA game controller.
- Advances one player sprite, N_HAZ hazard sprites and N_PICK pickup sprites once per frame.
- Detects pixel-accurate collisions during the raster scan and runs a lives/score game FSM.
- Sits between the VGA timing generator (hCount/vCount/bright/frame_tick) and the RGB output pins.
- Single clock domain: clk is the pixel clock; frame_tick replaces the separate slow clock.

Parameters:
- N_HAZ, 5: number of hazard sprites (1..8).
- N_PICK, 3: number of pickup sprites (1..8).
- LIVES, 3: lives loaded on game start (1..7).
- WIN_SCORE, 8: score that ends the game in WIN (1..15).
- HIT_FRAMES, 60: frames spent in HIT before respawn.
- X_MIN / X_MAX, 144 / 784: horizontal playfield bounds, inclusive.
- Y_MIN / Y_MAX, 40 / 512: vertical player bounds, inclusive.
- P_X0 / P_Y0, 200 / 250: player spawn position.
- HAZ_X0 / HAZ_Y0, N_HAZ×10 bits: packed spawn positions, index 0 in LSBs.
- HAZ_SPD, N_HAZ×3 bits: packed per-hazard leftward speed in px/frame, 1..7.
- PICK_X0 / PICK_Y0, N_PICK×10 bits: packed pickup spawn positions.
- PICK_SPD, N_PICK×3 bits: packed pickup speeds, 1..7.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, issued during vertical blanking.
- hCount, vCount  in  10 each  raster position.
- bright  in  1  visible-area flag.
- start, up, down  in  1 each  debounced, level-sensitive buttons.
- rgb  out  12  registered pixel colour.
- score  out  4  current score.
- lives  out  3  lives remaining.
- game_state  out  3  0=IDLE, 1=PLAY, 2=HIT, 3=OVER, 4=WIN.

Behaviour:
- Reset (rst=1):
  - Outputs: rgb=0, score=0, lives=LIVES, game_state=IDLE.
  - All sprites at their spawn positions; all collision latches cleared.
- Sprite boxes, inclusive:
  - Player: x±5, y±5.
  - Hazard: x±10, y±5.
  - Pickup: x±2, y±4.
- Pixel path:
  - rgb is registered, 1-cycle latency from hCount/vCount.
  - bright=0 → rgb=0.
  - Colour priority: player D97 > hazards (lowest index first, 058) > pickups (AEF) > sand band at vCount 490..520 (FF0) > background (0FF).
  - In HIT the player is drawn only while hit_cnt[3]=0 (blink).
- Collision latches:
  - Set on any cycle with bright=1, state=PLAY and the player box overlapping a hazard box (hit_latch) or pickup j's box (pick_latch[j]).
  - All latches clear on the cycle frame_tick is processed.
  - A set and a clear in the same cycle resolve to clear.
- frame_tick in PLAY, evaluated in this order:
  1. hit_latch=1: lives−1. Go to OVER if lives was 1, otherwise HIT with hit_cnt=0. Pickups are not scored this frame.
  2. Otherwise: score += popcount(pick_latch), saturating at WIN_SCORE. Each collected pickup respawns at x=X_MAX, same y. If the new score ≥ WIN_SCORE, go to WIN.
  3. Player y: up only → y−1, floored at Y_MIN. Down only → y+1, capped at Y_MAX. Both or neither → hold.
  4. Each hazard and pickup: x −= speed. If x < X_MIN+speed before the subtract, x wraps to X_MAX instead.
- HIT:
  - hit_cnt increments per frame_tick; sprites are frozen.
  - When hit_cnt=HIT_FRAMES−1: player, hazards and pickups reload their spawn positions, then go to PLAY.
- IDLE, OVER, WIN:
  - Sprites frozen.
  - start=1 at frame_tick: reload all spawn positions, score=0, lives=LIVES, go to PLAY.
  - start is ignored between frame_ticks.
- Game state changes only on frame_tick cycles.
- Asynchronous reset mid-frame returns to IDLE immediately; latches are lost.

Test Plan:
- Reset, then start=1 for one frame_tick → game_state=1, lives=3, score=0, player at (200,250).
- up held 300 frames from y=250 → y stops at 40, no underflow; up+down together → y unchanged.
- Hazard with x=150, speed 7, X_MIN=144 → next frame x=784; with x=151 → x=144.
- Player and pickup 0 overlap over 3 scanlines in one frame → score +1 (not +3); pickup 0 x=784 next frame.
- Hazard and pickup overlap in the same frame with lives=3 → lives=2, score unchanged, state HIT; after 60 ticks state PLAY with spawn positions restored.
- lives=1 plus hazard hit → OVER. score=7 plus pickup → score=8, WIN; start then returns to PLAY with score=0 and lives=3.

Source files
------------

// File: rtl/sprite_game_engine_if.sv
// Purpose : raster inputs, buttons and game/pixel outputs of sprite_game_engine.
// Latency : n/a (signal bundle only).
// Backpressure: none; raster and frame_tick are free-running from the VGA timing.
// Ports   : master drives frame_tick/hCount/vCount/bright/start/up/down and
//           observes rgb/score/lives/game_state; slave is the engine side.
interface sprite_game_engine_if;
  logic        frame_tick;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        start;
  logic        up;
  logic        down;
  logic [11:0] rgb;
  logic [3:0]  score;
  logic [2:0]  lives;
  logic [2:0]  game_state;

  modport master (
    output frame_tick, hCount, vCount, bright, start, up, down,
    input  rgb, score, lives, game_state
  );

  modport slave (
    input  frame_tick, hCount, vCount, bright, start, up, down,
    output rgb, score, lives, game_state
  );
endinterface

// File: rtl/sprite_game_engine.sv
// Purpose : per-frame sprite motion, pixel-accurate collision and lives/score FSM.
// Latency : rgb is registered, 1 cycle after hCount/vCount; game state moves on frame_tick.
// Backpressure: none; the engine follows the raster unconditionally.
// Ports   : clk (pixel clock), rst (async, active-high), bus (slave side of
//           sprite_game_engine_if: raster, buttons, rgb/score/lives/game_state).
module sprite_game_engine #(
  parameter int N_HAZ      = 5,
  parameter int N_PICK     = 3,
  parameter int LIVES      = 3,
  parameter int WIN_SCORE  = 8,
  parameter int HIT_FRAMES = 60,
  parameter int X_MIN      = 144,
  parameter int X_MAX      = 784,
  parameter int Y_MIN      = 40,
  parameter int Y_MAX      = 512,
  parameter int P_X0       = 200,
  parameter int P_Y0       = 250,
  parameter logic [N_HAZ*10-1:0]  HAZ_X0   = {10'd700, 10'd600, 10'd500, 10'd400, 10'd300},
  parameter logic [N_HAZ*10-1:0]  HAZ_Y0   = {10'd460, 10'd400, 10'd320, 10'd180, 10'd100},
  parameter logic [N_HAZ*3-1:0]   HAZ_SPD  = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
  parameter logic [N_PICK*10-1:0] PICK_X0  = {10'd750, 10'd550, 10'd350},
  parameter logic [N_PICK*10-1:0] PICK_Y0  = {10'd300, 10'd220, 10'd140},
  parameter logic [N_PICK*3-1:0]  PICK_SPD = {3'd3, 3'd2, 3'd1}
) (
  input logic                  clk,
  input logic                  rst,
  sprite_game_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_OVER = 3'd3,
    S_WIN  = 3'd4
  } state_t;

  localparam logic [9:0]  PX       = 10'(P_X0);
  localparam logic [9:0]  PY0      = 10'(P_Y0);
  localparam logic [9:0]  YMIN     = 10'(Y_MIN);
  localparam logic [9:0]  YMAX     = 10'(Y_MAX);
  localparam logic [9:0]  XMAXP    = 10'(X_MAX);
  localparam logic [10:0] XMIN11   = 11'(X_MIN);
  localparam logic [4:0]  WIN5     = 5'(WIN_SCORE);
  localparam logic [7:0]  HIT_LAST = 8'(HIT_FRAMES - 1);

  state_t            state;
  logic [3:0]        score;
  logic [2:0]        lives;
  logic [7:0]        hit_cnt;
  logic [9:0]        py;
  logic [9:0]        haz_x  [N_HAZ];
  logic [9:0]        pick_x [N_PICK];
  logic              hit_latch;
  logic [N_PICK-1:0] pick_latch;
  logic [11:0]       rgb_q;

  logic              in_p, any_h, any_k, hit_px, draw_p, reload, move;
  logic [N_PICK-1:0] pick_in, pick_px;
  logic [3:0]        pick_cnt;
  logic [4:0]        sum;
  logic [9:0]        py_nxt;
  logic [11:0]       pix;

  // Inclusive box test, done in 11 bits so cx-rx never underflows.
  function automatic logic in_box(input logic [9:0] h, input logic [9:0] v,
                                  input logic [9:0] cx, input logic [9:0] cy,
                                  input logic [3:0] rx, input logic [3:0] ry);
    logic [10:0] h1, v1, cx1, cy1;
    h1  = {1'b0, h};
    v1  = {1'b0, v};
    cx1 = {1'b0, cx};
    cy1 = {1'b0, cy};
    return (h1 + {7'd0, rx} >= cx1) && (h1 <= cx1 + {7'd0, rx}) &&
           (v1 + {7'd0, ry} >= cy1) && (v1 <= cy1 + {7'd0, ry});
  endfunction

  // Leftward step; a sprite that would pass X_MIN re-enters at X_MAX.
  function automatic logic [9:0] step_left(input logic [9:0] x, input logic [2:0] spd);
    if ({1'b0, x} < XMIN11 + {8'd0, spd}) return XMAXP;
    else                                  return x - {7'd0, spd};
  endfunction

  always_comb begin
    in_p    = in_box(bus.hCount, bus.vCount, PX, py, 4'd5, 4'd5);
    any_h   = 1'b0;
    any_k   = 1'b0;
    pick_in = '0;
    for (int i = 0; i < N_HAZ; i++)
      any_h = any_h | in_box(bus.hCount, bus.vCount, haz_x[i], HAZ_Y0[i*10 +: 10], 4'd10, 4'd5);
    for (int j = 0; j < N_PICK; j++) begin
      pick_in[j] = in_box(bus.hCount, bus.vCount, pick_x[j], PICK_Y0[j*10 +: 10], 4'd2, 4'd4);
      any_k      = any_k | pick_in[j];
    end
    hit_px  = in_p & any_h;
    pick_px = {N_PICK{in_p}} & pick_in;

    // Player blinks with a 16-frame period while recovering from a hit.
    draw_p = (state != S_HIT) || !hit_cnt[3];

    pix = 12'h0FF;
    if (bus.vCount >= 10'd490 && bus.vCount <= 10'd520) pix = 12'hFF0;
    if (any_k)           pix = 12'hAEF;
    if (any_h)           pix = 12'h058;
    if (in_p && draw_p)  pix = 12'hD97;
    if (!bus.bright)     pix = 12'h000;

    pick_cnt = '0;
    for (int j = 0; j < N_PICK; j++) pick_cnt = pick_cnt + {3'd0, pick_latch[j]};
    sum = {1'b0, score} + {1'b0, pick_cnt};

    py_nxt = py;
    if (bus.up && !bus.down && py > YMIN)      py_nxt = py - 10'd1;
    else if (bus.down && !bus.up && py < YMAX) py_nxt = py + 10'd1;

    reload = bus.frame_tick &&
             ((state == S_HIT && hit_cnt == HIT_LAST) ||
              ((state == S_IDLE || state == S_OVER || state == S_WIN) && bus.start));
    move   = bus.frame_tick && (state == S_PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      score      <= '0;
      lives      <= 3'(LIVES);
      hit_cnt    <= '0;
      hit_latch  <= 1'b0;
      pick_latch <= '0;
      rgb_q      <= '0;
      py         <= PY0;
      for (int i = 0; i < N_HAZ; i++)  haz_x[i]  <= HAZ_X0[i*10 +: 10];
      for (int j = 0; j < N_PICK; j++) pick_x[j] <= PICK_X0[j*10 +: 10];
    end else begin
      rgb_q <= pix;

      // frame_tick clears the latches, overriding any set on the same cycle.
      if (bus.frame_tick) begin
        hit_latch  <= 1'b0;
        pick_latch <= '0;
        case (state)
          S_PLAY: begin
            if (hit_latch) begin
              lives <= lives - 3'd1;
              if (lives == 3'd1) state <= S_OVER;
              else begin
                state   <= S_HIT;
                hit_cnt <= '0;
              end
            end else begin
              score <= (sum >= WIN5) ? 4'(WIN_SCORE) : sum[3:0];
              if (sum >= WIN5) state <= S_WIN;
            end
          end
          S_HIT: begin
            if (hit_cnt == HIT_LAST) state <= S_PLAY;
            else                     hit_cnt <= hit_cnt + 8'd1;
          end
          default: begin
            if (bus.start) begin
              score <= '0;
              lives <= 3'(LIVES);
              state <= S_PLAY;
            end
          end
        endcase
      end else if (bus.bright && state == S_PLAY) begin
        hit_latch  <= hit_latch | hit_px;
        pick_latch <= pick_latch | pick_px;
      end

      if (reload) begin
        py <= PY0;
        for (int i = 0; i < N_HAZ; i++)  haz_x[i]  <= HAZ_X0[i*10 +: 10];
        for (int j = 0; j < N_PICK; j++) pick_x[j] <= PICK_X0[j*10 +: 10];
      end else if (move) begin
        py <= py_nxt;
        for (int i = 0; i < N_HAZ; i++)
          haz_x[i] <= step_left(haz_x[i], HAZ_SPD[i*3 +: 3]);
        // Collected pickups re-enter at the right edge; a hit frame scores nothing.
        for (int j = 0; j < N_PICK; j++)
          pick_x[j] <= (!hit_latch && pick_latch[j]) ? XMAXP
                                                    : step_left(pick_x[j], PICK_SPD[j*3 +: 3]);
      end
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.score      = score;
  assign bus.lives      = lives;
  assign bus.game_state = state;

endmodule

// File: tb/tb_sprite_game_engine.sv
// Purpose : directed bench for sprite_game_engine with hand-computed expectations.
// Latency : outputs sampled on the falling edge, one cycle after inputs change.
// Backpressure: none; raster pixels and frame ticks are driven directly.
module tb_sprite_game_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  sprite_game_engine_if bus ();

  // Hazard 0/1 exercise the wrap boundary; hazard 2 sits just right of and
  // below the player; pickup 0 sits on top of the player at spawn.
  sprite_game_engine #(
    .N_HAZ   (3),
    .N_PICK  (2),
    .HAZ_X0  ({10'd215, 10'd151, 10'd150}),
    .HAZ_Y0  ({10'd256, 10'd100, 10'd300}),
    .HAZ_SPD ({3'd1, 3'd7, 3'd7}),
    .PICK_X0 ({10'd600, 10'd200}),
    .PICK_Y0 ({10'd400, 10'd250}),
    .PICK_SPD({3'd2, 3'd1})
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
    end
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic b, input int exp);
    @(negedge clk);
    bus.hCount = 10'(h);
    bus.vCount = 10'(v);
    bus.bright = b;
    @(negedge clk);
    check(tag, int'(bus.rgb), exp);
    bus.bright = 1'b0;
  endtask

  task automatic check_state(input string tag, input int st, input int lv, input int sc);
    check({tag, "_state"}, int'(bus.game_state), st);
    check({tag, "_lives"}, int'(bus.lives), lv);
    check({tag, "_score"}, int'(bus.score), sc);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.hCount = '0;
    bus.vCount = '0;
    bus.bright = 1'b0;
    bus.start  = 1'b0;
    bus.up     = 1'b0;
    bus.down   = 1'b0;

    // Reset
    #2 rst = 1'b1;
    #4;
    check_state("rst", 0, 3, 0);
    check("rst_rgb", int'(bus.rgb), 0);
    check("rst_py", int'(dut.py), 250);
    check("rst_h0x", int'(dut.haz_x[0]), 150);
    @(negedge clk) rst = 1'b0;

    pix("idle_bg", 400, 300, 1'b1, 12'h0FF);
    tick(2);
    check("idle_no_start", int'(bus.game_state), 0);

    // Start
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check_state("start", 1, 3, 0);
    check("start_py", int'(dut.py), 250);

    // Colour priority, non-colliding pixels
    pix("px_bg", 400, 300, 1'b1, 12'h0FF);
    pix("px_sand", 400, 500, 1'b1, 12'hFF0);
    pix("px_haz", 150, 300, 1'b1, 12'h058);
    pix("px_pick", 600, 400, 1'b1, 12'hAEF);
    pix("px_player", 197, 250, 1'b1, 12'hD97);
    pix("px_dark", 197, 250, 1'b0, 12'h000);

    // Hazard and pickup in the same frame: hit wins, no score
    pix("hit_pk_px", 200, 247, 1'b1, 12'hD97);
    pix("hit_hz_px", 205, 253, 1'b1, 12'hD97);
    tick(1);
    check_state("hit1", 2, 2, 0);
    pix("blink_on", 196, 250, 1'b1, 12'hD97);
    tick(8);
    pix("blink_off", 196, 250, 1'b1, 12'h0FF);
    tick(51);
    check("hit_59", int'(bus.game_state), 2);
    tick(1);
    check("hit_60", int'(bus.game_state), 1);
    check("respawn_py", int'(dut.py), 250);
    check("respawn_h0", int'(dut.haz_x[0]), 150);
    check("respawn_h2", int'(dut.haz_x[2]), 215);
    check("respawn_p0", int'(dut.pick_x[0]), 200);

    // Pickup over three scanlines scores once; hazard wrap boundary
    pix("pk_r0", 200, 247, 1'b1, 12'hD97);
    pix("pk_r1", 200, 248, 1'b1, 12'hD97);
    pix("pk_r2", 200, 249, 1'b1, 12'hD97);
    tick(1);
    check_state("pick", 1, 2, 1);
    check("pick_p0x", int'(dut.pick_x[0]), 784);
    check("pick_p1x", int'(dut.pick_x[1]), 598);
    check("wrap_150", int'(dut.haz_x[0]), 784);
    check("wrap_151", int'(dut.haz_x[1]), 144);

    // Player vertical movement
    bus.up = 1'b1;
    tick(300);
    check("up_floor", int'(dut.py), 40);
    bus.down = 1'b1;
    tick(3);
    check("up_down_hold", int'(dut.py), 40);
    bus.up = 1'b0;
    tick(5);
    bus.down = 1'b0;
    check("down5", int'(dut.py), 45);

    // Asynchronous reset mid-game
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_state("arst", 0, 3, 0);
    check("arst_rgb", int'(bus.rgb), 0);
    @(negedge clk) rst = 1'b0;

    // Three hits: lives 3 -> 2 -> 1 -> OVER
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pix("hit_px", 205, 253, 1'b1, 12'hD97);
      tick(1);
      check_state("hitn", 2, 2 - k, 0);
      tick(60);
      check("hitn_play", int'(bus.game_state), 1);
    end
    pix("last_hit_px", 205, 253, 1'b1, 12'hD97);
    tick(1);
    check_state("over", 3, 0, 0);
    tick(2);
    check("over_hold", int'(bus.game_state), 3);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check_state("over_restart", 1, 3, 0);

    // Eight pickups: score saturates at WIN_SCORE and the game is won
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        tick(584);
        check("p0_back", int'(dut.pick_x[0]), 200);
      end
      pix("win_pk_px", 200, 247, 1'b1, 12'hD97);
      tick(1);
      check("win_score", int'(bus.score), k);
    end
    check("win_state", int'(bus.game_state), 4);
    tick(2);
    check("win_hold", int'(bus.game_state), 4);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check_state("win_restart", 1, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
